// File: rtl/event_order_monitor.sv
// Ordered event-bus monitor: consumes event lines 0..N-1 in ascending order and flags stale, out-of-order or missing events.
// Optional `EVENT_MON_LATCH_EN: early events are latched into a pending vector instead of failing.
module event_order_monitor #(
    parameter int unsigned N       = 100,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned IDXW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    events,
    output logic [IDXW-1:0] waiting_idx,
    output logic            matched,
    output logic [IDXW-1:0] matched_idx,
    output logic            done,
    output logic            fail,
    output logic [1:0]      err_code,
    output logic [IDXW-1:0] err_idx
);

    localparam int unsigned TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [TCW-1:0] TC_MAX = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] FAIL  = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNEXP   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] exp_q, exp_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic            matched_q, matched_d;
    logic [IDXW-1:0] matched_idx_q, matched_idx_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [IDXW-1:0] err_idx_q, err_idx_d;
`ifdef EVENT_MON_LATCH_EN
    logic [N-1:0]    pending_q, pending_d;
`endif

    logic [N-1:0]    cand;
    logic            bad_found;
    logic [IDXW-1:0] bad_idx;
    logic            arm;

    // Candidate set and lowest-index search for bits that violate ordering.
    always_comb begin
`ifdef EVENT_MON_LATCH_EN
        cand = events | pending_q;
`else
        cand = events;
`endif
        bad_found = 1'b0;
        bad_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
`ifdef EVENT_MON_LATCH_EN
            if (cand[i] && (IDXW'(i) < exp_q)) begin
`else
            if (cand[i] && (IDXW'(i) != exp_q)) begin
`endif
                bad_found = 1'b1;
                bad_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        tcnt_d        = tcnt_q;
        matched_d     = 1'b0;
        matched_idx_d = matched_idx_q;
        done_d        = done_q;
        fail_d        = fail_q;
        err_code_d    = err_code_q;
        err_idx_d     = err_idx_q;
`ifdef EVENT_MON_LATCH_EN
        pending_d     = pending_q;
`endif
        arm           = 1'b0;

        case (state_q)
            IDLE, DONE, FAIL: begin
                arm = start;
            end
            WAIT: begin
                if (bad_found) begin
                    state_d    = FAIL;
                    fail_d     = 1'b1;
                    err_code_d = ERR_UNEXP;
                    err_idx_d  = bad_idx;
                end else if (cand[exp_q]) begin
                    matched_d     = 1'b1;
                    matched_idx_d = exp_q;
                    tcnt_d        = '0;
`ifdef EVENT_MON_LATCH_EN
                    pending_d        = cand;
                    pending_d[exp_q] = 1'b0;
`endif
                    if (exp_q == IDXW'(N - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        exp_d = exp_q + IDXW'(1);
                    end
                end else begin
`ifdef EVENT_MON_LATCH_EN
                    pending_d = cand;
`endif
                    // Saturating wait counter; only compared when the timeout is enabled.
                    if (tcnt_q != TC_MAX) begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                    if (TO_EN && (tcnt_d == TCW'(TIMEOUT))) begin
                        state_d    = FAIL;
                        fail_d     = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        err_idx_d  = exp_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Arming WAIT starts a fresh sequence and clears any sticky status.
        if (arm) begin
            state_d    = WAIT;
            exp_d      = '0;
            tcnt_d     = '0;
            done_d     = 1'b0;
            fail_d     = 1'b0;
            err_code_d = ERR_NONE;
            err_idx_d  = '0;
`ifdef EVENT_MON_LATCH_EN
            pending_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            exp_q         <= '0;
            tcnt_q        <= '0;
            matched_q     <= 1'b0;
            matched_idx_q <= '0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_idx_q     <= '0;
`ifdef EVENT_MON_LATCH_EN
            pending_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            tcnt_q        <= tcnt_d;
            matched_q     <= matched_d;
            matched_idx_q <= matched_idx_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            err_code_q    <= err_code_d;
            err_idx_q     <= err_idx_d;
`ifdef EVENT_MON_LATCH_EN
            pending_q     <= pending_d;
`endif
        end
    end

    // exp is cleared on reset and on every arm, so it doubles as the awaited-index output.
    assign waiting_idx = exp_q;
    assign matched     = matched_q;
    assign matched_idx = matched_idx_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign err_code    = err_code_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_event_order_monitor.sv
// Directed bench for event_order_monitor with N=4, TIMEOUT=8; strict table in the default build, latch sequence with EVENT_MON_LATCH_EN.
module tb_event_order_monitor;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  events;
    logic [IW-1:0] waiting_idx;
    logic          matched;
    logic [IW-1:0] matched_idx;
    logic          done;
    logic          fail;
    logic [1:0]    err_code;
    logic [IW-1:0] err_idx;

    int checks = 0;
    int errors = 0;

    event_order_monitor #(.N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .events      (events),
        .waiting_idx (waiting_idx),
        .matched     (matched),
        .matched_idx (matched_idx),
        .done        (done),
        .fail        (fail),
        .err_code    (err_code),
        .err_idx     (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] ev;
        logic       m;
        logic [1:0] midx;
        logic       d;
        logic       f;
        logic [1:0] code;
        logic [1:0] eidx;
        logic [1:0] widx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic [3:0] e, logic m, logic [1:0] mi,
                                logic d, logic f, logic [1:0] c, logic [1:0] ei, logic [1:0] wi);
        vec_t v;
        v.rst = r; v.start = s; v.ev = e; v.m = m; v.midx = mi;
        v.d = d; v.f = f; v.code = c; v.eidx = ei; v.widx = wi;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] e);
        rst = r; start = s; events = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic m, input logic [1:0] mi, input logic d,
                           input logic f, input logic [1:0] c, input logic [1:0] ei, input logic [1:0] wi);
        chk({tag, ".matched"},     int'(matched),     int'(m));
        if (m) chk({tag, ".matched_idx"}, int'(matched_idx), int'(mi));
        chk({tag, ".done"},        int'(done),        int'(d));
        chk({tag, ".fail"},        int'(fail),        int'(f));
        chk({tag, ".err_code"},    int'(err_code),    int'(c));
        chk({tag, ".err_idx"},     int'(err_idx),     int'(ei));
        chk({tag, ".waiting_idx"}, int'(waiting_idx), int'(wi));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; events = '0;
        @(posedge clk); #1;

`ifndef EVENT_MON_LATCH_EN
        //             rst  st   ev      m  mi d  f  code ei wi
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0)); // reset state
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0)); // arm
        vecs.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 4'b0100, 1, 2, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 4'b1000, 1, 3, 1, 0, 0, 0, 3)); // done with last match
        vecs.push_back(mk(0, 0, 4'b0010, 0, 3, 1, 0, 0, 0, 3)); // ignored in DONE
        vecs.push_back(mk(0, 1, 4'b0000, 0, 3, 0, 0, 0, 0, 0)); // restart clears done
        vecs.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0100, 0, 0, 0, 1, 1, 2, 1)); // out of order
        vecs.push_back(mk(0, 0, 4'b0010, 0, 0, 0, 1, 1, 2, 1)); // ignored in FAIL
        vecs.push_back(mk(0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0)); // event in arm cycle not sampled
        vecs.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0)); // reset at exp=2
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0011, 0, 0, 0, 1, 1, 0, 1)); // stale 0 beats expected 1
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0, 1, 1, 2, 0)); // extra bit fails despite exp set
        vecs.push_back(mk(0, 0, 4'b1001, 0, 0, 0, 1, 1, 2, 0)); // sticky error

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].ev);
            chk_all($sformatf("vec%0d", i), vecs[i].m, vecs[i].midx, vecs[i].d,
                    vecs[i].f, vecs[i].code, vecs[i].eidx, vecs[i].widx);
            if (!vecs[i].m) chk($sformatf("vec%0d.matched_idx", i), int'(matched_idx), int'(vecs[i].midx));
        end

        // Timeout at exp=0: silent for TIMEOUT-1 WAIT edges, fail after the TIMEOUT-th.
        step(0, 1, 4'b0000);
        for (int k = 1; k < int'(TO); k++) begin
            step(0, 0, 4'b0000);
            chk($sformatf("to0_edge%0d.fail", k), int'(fail), 0);
        end
        step(0, 0, 4'b0000);
        chk_all("to0_expire", 0, 0, 0, 1, 2, 0, 0);

        // A match restarts the count; timeout then reports the new awaited index.
        step(0, 1, 4'b0000);
        step(0, 0, 4'b0001);
        chk_all("to1_match", 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k < int'(TO); k++) begin
            step(0, 0, 4'b0000);
            chk($sformatf("to1_edge%0d.fail", k), int'(fail), 0);
        end
        step(0, 0, 4'b0000);
        chk_all("to1_expire", 0, 0, 0, 1, 2, 1, 1);
`else
        // Early events latch into pending and are consumed without new pulses.
        step(0, 1, 4'b0000);
        chk_all("lat_arm", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'b1100);
        chk_all("lat_early", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'b0001);
        chk_all("lat_m0", 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 4'b0010);
        chk_all("lat_m1", 1, 1, 0, 0, 0, 0, 2);
        step(0, 0, 4'b0000);
        chk_all("lat_m2", 1, 2, 0, 0, 0, 0, 3);
        step(0, 0, 4'b0000);
        chk_all("lat_m3", 1, 3, 1, 0, 0, 0, 3);
        // Stale event still fails.
        step(0, 1, 4'b0000);
        step(0, 0, 4'b0001);
        chk_all("lat_s0", 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 4'b0011);
        chk_all("lat_stale", 0, 0, 0, 1, 1, 0, 1);
        step(1, 0, 4'b0000);
        chk_all("lat_rst", 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
